dac_tone_mixer: RTL and testbench

- Parametrised multi-channel successor to the single-tone DAC generator.
- NCH phase-accumulator (DDS) tone channels, each enabled by one switch bit, each tunable at run time.
- Shared waveform mode (square/saw/triangle/mute); channels are averaged into one DATA_W-bit unsigned sample at a fixed rate.
- Each sample is shipped to the board DAC as an SPI frame (command prefix + sample); the parallel sample is also exported for display.

---
 rtl/dac_tone_mixer.sv | 160 ++++++++++++++++
 tb/tb_dac_tone_mixer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_tone_mixer.sv
// dac_tone_mixer: multi-channel DDS tone mixer that ships each averaged sample to the DAC over SPI
module dac_tone_mixer #(
    parameter int NCH = 4,
    parameter int ACC_W = 24,
    parameter int DATA_W = 16,
    parameter int SAMPLE_DIV = 2500,
    parameter int SCLK_DIV = 4,
    parameter int CMD_W = 8,
    parameter logic [CMD_W-1:0] CMD = 8'h30,
    parameter logic [ACC_W-1:0] BASE_TUNE = 24'h00B3C5,
    localparam int TW = NCH > 1 ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    switches_in,
    input  logic [1:0]        mode_in,
    input  logic              tune_wr,
    input  logic [TW-1:0]     tune_ch,
    input  logic [ACC_W-1:0]  tune_word,
    output logic [DATA_W-1:0] dac_data,
    output logic              sample_valid,
    output logic              spi_data,
    output logic              spi_clk,
    output logic              spi_sync,
    output logic              busy,
    output logic              overrun
);
    localparam int LG = $clog2(NCH);
    localparam int FW = CMD_W + DATA_W;
    localparam int CW = $clog2(SAMPLE_DIV + 1);
    localparam int SC = $clog2(SCLK_DIV + 1);
    localparam int BC = $clog2(FW + 1);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_TAIL} state_t;

    logic [CW-1:0]        r_div;
    logic                 r_tick_d;
    logic [ACC_W-1:0]     r_acc [NCH];
    logic [ACC_W-1:0]     r_tune [NCH];
    logic                 w_tick;
    logic [DATA_W+LG-1:0] w_sum;
    logic [DATA_W-1:0]    w_mix;
    state_t               r_state;
    logic [FW-1:0]        r_shift;
    logic [SC-1:0]        r_cnt;
    logic [BC-1:0]        r_bit;
    logic                 w_last;

    function automatic logic [DATA_W-1:0] wave(input logic [ACC_W-1:0] a, input logic [1:0] m);
        logic [DATA_W-2:0] t;
        t = a[ACC_W-2 -: DATA_W-1];
        return m == 2'b00 ? {DATA_W{a[ACC_W-1]}} : m == 2'b01 ? a[ACC_W-1 -: DATA_W] : {a[ACC_W-1] ? ~t : t, 1'b0};
    endfunction

    assign w_tick = r_div == CW'(SAMPLE_DIV - 1);
    assign w_last = r_cnt == SC'(SCLK_DIV - 1);

    // sample-rate divider; the delayed tick times the mix register one cycle after the phase step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            r_tick_d <= w_tick;
        end
    end

    // tune writes and per-tick phase advance; a disabled channel parks its phase at zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                r_tune[k] <= ACC_W'(BASE_TUNE * ACC_W'(k + 1));
                r_acc[k] <= '0;
            end
        end else begin
            if (tune_wr && int'(tune_ch) < NCH) r_tune[tune_ch] <= tune_word;
            if (w_tick)
                for (int k = 0; k < NCH; k++) r_acc[k] <= switches_in[k] ? r_acc[k] + r_tune[k] : '0;
        end
    end

    // average of enabled channel waveforms; silence sits at midscale
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NCH; k++)
            w_sum = w_sum + (switches_in[k] ? (DATA_W+LG)'(wave(r_acc[k], mode_in)) : '0);
        w_mix = (switches_in == '0 || mode_in == 2'b11) ? MID : w_sum[DATA_W+LG-1 -: DATA_W];
    end

    // mixed sample register with its one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dac_data <= MID;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= r_tick_d;
            if (r_tick_d) dac_data <= w_mix;
        end
    end

    // SPI frame engine: launch on a fresh sample when idle, shift MSB first, flag dropped samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt <= '0;
            r_bit <= '0;
            spi_data <= 1'b0;
            spi_clk <= 1'b0;
            spi_sync <= 1'b1;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sample_valid && busy) overrun <= 1'b1;
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: if (sample_valid) begin
                    r_shift <= {CMD, dac_data};
                    spi_data <= CMD[CMD_W-1];
                    spi_sync <= 1'b0;
                    busy <= 1'b1;
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_state <= S_SETUP;
                end
                S_SETUP: if (w_last) begin
                    spi_clk <= 1'b1;
                    spi_data <= r_shift[FW-1];
                    r_cnt <= '0;
                    r_state <= S_HIGH;
                end
                S_HIGH: if (w_last) begin
                    spi_clk <= 1'b0;
                    r_shift <= r_shift << 1;
                    r_cnt <= '0;
                    r_state <= S_LOW;
                end
                S_LOW: if (w_last) begin
                    r_cnt <= '0;
                    if (r_bit == BC'(FW - 1)) begin
                        spi_sync <= 1'b1;
                        r_state <= S_TAIL;
                    end else begin
                        spi_clk <= 1'b1;
                        spi_data <= r_shift[FW-1];
                        r_bit <= r_bit + 1'b1;
                        r_state <= S_HIGH;
                    end
                end
                S_TAIL: if (w_last) begin
                    busy <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_tone_mixer.sv
// tb_dac_tone_mixer: randomized and directed checks of the tone mixer against an arithmetic model
module tb_dac_tone_mixer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  switches_in;
    logic [1:0]  mode_in;
    logic        tune_wr;
    logic [1:0]  tune_ch;
    logic [23:0] tune_word;
    logic [15:0] dac_data;
    logic        sample_valid, spi_data, spi_clk, spi_sync, busy, overrun;

    logic        rst2_n, sw2, wr2, ch2;
    logic [1:0]  mode2;
    logic [23:0] word2;
    logic [15:0] d2_dac;
    logic        d2_valid, d2_data, d2_clk, d2_sync, d2_busy, d2_overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned m_acc [4];
    int unsigned m_tune [4];

    localparam int unsigned M24 = 32'h1000000;
    localparam int unsigned HALF = 32'h800000;

    always #5 clk = ~clk;

    dac_tone_mixer #(.SAMPLE_DIV(300)) dut (
        .clk(clk), .reset_n(reset_n), .switches_in(switches_in), .mode_in(mode_in),
        .tune_wr(tune_wr), .tune_ch(tune_ch), .tune_word(tune_word),
        .dac_data(dac_data), .sample_valid(sample_valid), .spi_data(spi_data),
        .spi_clk(spi_clk), .spi_sync(spi_sync), .busy(busy), .overrun(overrun)
    );

    dac_tone_mixer #(.NCH(1), .SAMPLE_DIV(100)) dut2 (
        .clk(clk), .reset_n(rst2_n), .switches_in(sw2), .mode_in(mode2),
        .tune_wr(wr2), .tune_ch(ch2), .tune_word(word2),
        .dac_data(d2_dac), .sample_valid(d2_valid), .spi_data(d2_data),
        .spi_clk(d2_clk), .spi_sync(d2_sync), .busy(d2_busy), .overrun(d2_overrun)
    );

    // single-channel waveform value straight from the phase, using plain arithmetic
    function automatic int unsigned wave_ref(int unsigned a, int unsigned m);
        int unsigned lo;
        lo = (a % HALF) / 256;
        if (m == 0) return a >= HALF ? 65535 : 0;
        if (m == 1) return a / 256;
        return 2 * (a >= HALF ? 32767 - lo : lo);
    endfunction

    // expected mixed sample: mean over all channel slots of the enabled channels' waveforms
    function automatic logic [15:0] mix_ref();
        int unsigned s = 0;
        if (switches_in == 4'b0 || mode_in == 2'b11) return 16'h8000;
        for (int k = 0; k < 4; k++) if (switches_in[k]) s += wave_ref(m_acc[k], mode_in);
        return 16'(s / 4);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_tune[k] = (32'hB3C5 * (k + 1)) % M24;
        end
    endtask

    // bounded wait for the next sample, then advance the model by one tick
    task automatic wait_sample();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 400);
        if (!sample_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sample_timeout: sample_valid=%b required 1 within 400 cycles", sample_valid);
        end
        for (int k = 0; k < 4; k++) m_acc[k] = switches_in[k] ? (m_acc[k] + m_tune[k]) % M24 : 0;
    endtask

    task automatic write_tune(input int ch, input logic [23:0] w);
        tune_wr = 1'b1;
        tune_ch = 2'(ch);
        tune_word = w;
        @(negedge clk);
        tune_wr = 1'b0;
        m_tune[ch] = w;
    endtask

    // records one SPI frame: bits taken at spi_clk falling edges, plus timing counts
    task automatic capture(output logic [23:0] bits, output int pulses, output int sync_lo,
                           output int busy_n, output int glitches);
        logic pc, pd, ps;
        bits = '0;
        pulses = 0;
        sync_lo = 0;
        busy_n = 0;
        glitches = 0;
        pc = spi_clk;
        pd = spi_data;
        ps = spi_sync;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (!spi_sync) sync_lo++;
            if (spi_clk && !pc) pulses++;
            if (!spi_clk && pc) bits = {bits[22:0], spi_data};
            if (spi_data !== pd && !(spi_clk && !pc) && !ps) glitches++;
            pc = spi_clk;
            pd = spi_data;
            ps = spi_sync;
            if (busy_n > 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        switches_in = 4'b0;
        mode_in = 2'b00;
        tune_wr = 1'b0;
        tune_ch = 2'b0;
        tune_word = 24'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        n_cmp++;
        if ({dac_data, sample_valid, spi_sync, spi_clk, spi_data, busy, overrun} !== {16'h8000, 6'b010000}) begin
            n_bad++;
            $display("FAIL reset: dac=%h valid=%b sync=%b sclk=%b sdata=%b busy=%b ovr=%b required 8000 0 1 0 0 0 0",
                     dac_data, sample_valid, spi_sync, spi_clk, spi_data, busy, overrun);
        end
    endtask

    task automatic test_first_frame();
        logic [23:0] bits;
        int p, s, b, g;
        wait_sample();
        n_cmp++;
        if (dac_data !== 16'h8000) begin
            n_bad++;
            $display("FAIL first_sample: dac_data=%h required 8000", dac_data);
        end
        capture(bits, p, s, b, g);
        n_cmp++;
        if (bits !== 24'h308000) begin
            n_bad++;
            $display("FAIL first_frame_bits: got %h required 308000", bits);
        end
        n_cmp++;
        if (p != 24 || s != 196 || b != 200 || g != 0) begin
            n_bad++;
            $display("FAIL first_frame_timing: pulses=%0d sync_low=%0d busy=%0d glitches=%0d required 24 196 200 0", p, s, b, g);
        end
    endtask

    task automatic test_square();
        logic [15:0] e;
        write_tune(0, 24'h400000);
        switches_in = 4'b0001;
        mode_in = 2'b00;
        for (int i = 0; i < 4; i++) begin
            wait_sample();
            e = mix_ref();
            n_cmp++;
            if (dac_data !== e) begin
                n_bad++;
                $display("FAIL square[%0d]: dac_data=%h required %h", i, dac_data, e);
            end
        end
    endtask

    task automatic test_saw();
        logic [15:0] e;
        for (int k = 0; k < 4; k++) write_tune(k, 24'h100000);
        switches_in = 4'b1111;
        mode_in = 2'b01;
        for (int i = 0; i < 16; i++) begin
            wait_sample();
            e = mix_ref();
            n_cmp++;
            if (dac_data !== e) begin
                n_bad++;
                $display("FAIL saw[%0d]: dac_data=%h required %h", i, dac_data, e);
            end
        end
    endtask

    task automatic test_triangle_mute();
        logic [15:0] e;
        for (int k = 0; k < 4; k++) write_tune(k, 24'h7FFFFF);
        mode_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            wait_sample();
            e = mix_ref();
            n_cmp++;
            if (dac_data !== e) begin
                n_bad++;
                $display("FAIL triangle[%0d]: dac_data=%h required %h", i, dac_data, e);
            end
        end
        mode_in = 2'b11;
        wait_sample();
        n_cmp++;
        if (dac_data !== 16'h8000) begin
            n_bad++;
            $display("FAIL mute: dac_data=%h required 8000", dac_data);
        end
    endtask

    // a tune write landing in the tick cycle must only affect the following tick
    task automatic test_tune_on_tick();
        logic [15:0] e;
        switches_in = 4'b0001;
        mode_in = 2'b01;
        write_tune(0, 24'h010000);
        wait_sample();
        repeat (298) @(negedge clk);
        tune_wr = 1'b1;
        tune_ch = 2'd0;
        tune_word = 24'h020000;
        @(negedge clk);
        tune_wr = 1'b0;
        wait_sample();
        m_tune[0] = 24'h020000;
        e = mix_ref();
        n_cmp++;
        if (dac_data !== e) begin
            n_bad++;
            $display("FAIL tune_on_tick_old: dac_data=%h required %h", dac_data, e);
        end
        wait_sample();
        e = mix_ref();
        n_cmp++;
        if (dac_data !== e) begin
            n_bad++;
            $display("FAIL tune_on_tick_new: dac_data=%h required %h", dac_data, e);
        end
    endtask

    task automatic test_random();
        logic [15:0] e;
        logic [23:0] bits;
        int p, s, b, g;
        for (int i = 0; i < 8; i++) begin
            switches_in = 4'($urandom_range(0, 15));
            mode_in = 2'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) write_tune($urandom_range(0, 3), 24'($urandom));
            wait_sample();
            e = mix_ref();
            n_cmp++;
            if (dac_data !== e) begin
                n_bad++;
                $display("FAIL random_mix[%0d]: dac_data=%h required %h", i, dac_data, e);
            end
            capture(bits, p, s, b, g);
            n_cmp++;
            if (bits !== {8'h30, e}) begin
                n_bad++;
                $display("FAIL random_frame[%0d]: got %h required %h", i, bits, {8'h30, e});
            end
            n_cmp++;
            if (p != 24 || s != 196 || b != 200 || g != 0) begin
                n_bad++;
                $display("FAIL random_timing[%0d]: pulses=%0d sync_low=%0d busy=%0d glitches=%0d required 24 196 200 0", i, p, s, b, g);
            end
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL no_overrun: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_reset_midframe();
        wait_sample();
        repeat (60) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || spi_sync !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_active: busy=%b sync=%b required 1 0", busy, spi_sync);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({spi_sync, spi_clk, busy, overrun, dac_data} !== {4'b1000, 16'h8000}) begin
            n_bad++;
            $display("FAIL midframe_reset: sync=%b sclk=%b busy=%b ovr=%b dac=%h required 1 0 0 0 8000",
                     spi_sync, spi_clk, busy, overrun, dac_data);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    // single channel, fast sample rate: ignored out-of-range tune write and sticky overrun
    task automatic test_nch1_overrun();
        int n;
        logic [15:0] req [2] = '{16'h00B3, 16'h0167};
        rst2_n = 1'b0;
        sw2 = 1'b1;
        mode2 = 2'b01;
        wr2 = 1'b0;
        ch2 = 1'b0;
        word2 = 24'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        wr2 = 1'b1;
        ch2 = 1'b1;
        word2 = 24'h400000;
        @(negedge clk);
        wr2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!d2_valid && n < 300);
            n_cmp++;
            if (!d2_valid || d2_dac !== req[i]) begin
                n_bad++;
                $display("FAIL nch1_sample[%0d]: valid=%b dac_data=%h required 1 %h", i, d2_valid, d2_dac, req[i]);
            end
            n_cmp++;
            if (d2_overrun !== 1'b0 || d2_busy !== (i == 1)) begin
                n_bad++;
                $display("FAIL nch1_state[%0d]: overrun=%b busy=%b required 0 %b", i, d2_overrun, d2_busy, i == 1);
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (d2_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: overrun=%b required 1", d2_overrun);
        end
    endtask

    initial begin
        rst2_n = 1'b0;
        sw2 = 1'b0;
        mode2 = 2'b00;
        wr2 = 1'b0;
        ch2 = 1'b0;
        word2 = 24'b0;
        test_reset();
        test_first_frame();
        test_square();
        test_saw();
        test_triangle_mute();
        test_tune_on_tick();
        test_random();
        test_reset_midframe();
        test_nch1_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded 5 ms");
        $fatal(1, "watchdog");
    end
endmodule
